// File: rtl/axil4_master_wr_ctrl.sv
// AXI-Lite write-path master adapter: AW/W/B FIFOs, outstanding-write cap, BRESP error count.
// Optional macro AXIL_WR_TIMEOUT_EN adds a stalled-response watchdog (timeout_err tied low otherwise).

module axil4_wr_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             aclk,
   input  logic             areset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push;
   logic             pop;

   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   always_ff @(posedge aclk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end
endmodule

module axil4_master_wr_ctrl #(
   parameter int AXIL_ADDR_WIDTH = 32,
   parameter int AXIL_DATA_WIDTH = 32,
   parameter int SKID_DEPTH_AW   = 2,
   parameter int SKID_DEPTH_W    = 2,
   parameter int SKID_DEPTH_B    = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int ERR_CNT_WIDTH   = 16
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic [AXIL_ADDR_WIDTH-1:0]   fub_awaddr,
   input  logic [2:0]                   fub_awprot,
   input  logic                         fub_awvalid,
   output logic                         fub_awready,
   input  logic [AXIL_DATA_WIDTH-1:0]   fub_wdata,
   input  logic [AXIL_DATA_WIDTH/8-1:0] fub_wstrb,
   input  logic                         fub_wvalid,
   output logic                         fub_wready,
   output logic [1:0]                   fub_bresp,
   output logic                         fub_bvalid,
   input  logic                         fub_bready,
   output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
   output logic [2:0]                   m_axil_awprot,
   output logic                         m_axil_awvalid,
   input  logic                         m_axil_awready,
   output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
   output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
   output logic                         m_axil_wvalid,
   input  logic                         m_axil_wready,
   input  logic [1:0]                   m_axil_bresp,
   input  logic                         m_axil_bvalid,
   output logic                         m_axil_bready,
   output logic [3:0]                   outstanding,
   output logic [ERR_CNT_WIDTH-1:0]     err_count,
   output logic                         timeout_err,
   input  logic                         err_clear,
   output logic                         busy
);
   localparam int AWW = AXIL_ADDR_WIDTH + 3;
   localparam int WW  = AXIL_DATA_WIDTH + AXIL_DATA_WIDTH / 8;

   logic [AWW-1:0]           aw_head;
   logic                     aw_nempty;
   logic [WW-1:0]            w_head;
   logic                     b_nempty;
   logic                     cap_ok;
   logic                     aw_hs;
   logic                     b_hs;
   logic [3:0]               outstanding_q, outstanding_d;
   logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

   assign cap_ok         = (outstanding_q < 4'(MAX_OUTSTANDING));
   assign m_axil_awvalid = aw_nempty & cap_ok;
   assign aw_hs          = m_axil_awvalid & m_axil_awready;
   assign b_hs           = m_axil_bvalid & m_axil_bready;
   assign {m_axil_awprot, m_axil_awaddr} = aw_head;
   assign {m_axil_wstrb, m_axil_wdata}   = w_head;

   axil4_wr_fifo #(.WIDTH(AWW), .DEPTH(SKID_DEPTH_AW)) u_aw_fifo (
      .aclk      (aclk),
      .areset    (areset),
      .in_data   ({fub_awprot, fub_awaddr}),
      .in_valid  (fub_awvalid),
      .in_ready  (fub_awready),
      .out_data  (aw_head),
      .out_valid (aw_nempty),
      .out_ready (m_axil_awready & cap_ok)
   );

   axil4_wr_fifo #(.WIDTH(WW), .DEPTH(SKID_DEPTH_W)) u_w_fifo (
      .aclk      (aclk),
      .areset    (areset),
      .in_data   ({fub_wstrb, fub_wdata}),
      .in_valid  (fub_wvalid),
      .in_ready  (fub_wready),
      .out_data  (w_head),
      .out_valid (m_axil_wvalid),
      .out_ready (m_axil_wready)
   );

   axil4_wr_fifo #(.WIDTH(2), .DEPTH(SKID_DEPTH_B)) u_b_fifo (
      .aclk      (aclk),
      .areset    (areset),
      .in_data   (m_axil_bresp),
      .in_valid  (m_axil_bvalid),
      .in_ready  (m_axil_bready),
      .out_data  (fub_bresp),
      .out_valid (b_nempty),
      .out_ready (fub_bready)
   );
   assign fub_bvalid = b_nempty;

   // A B handshake with nothing outstanding is a protocol violation; hold at zero
   always_comb begin
      outstanding_d = outstanding_q;
      if (aw_hs && !b_hs)
         outstanding_d = outstanding_q + 4'd1;
      else if (b_hs && !aw_hs && (outstanding_q != 4'd0))
         outstanding_d = outstanding_q - 4'd1;
   end

   always_comb begin
      err_d = err_q;
      if (err_clear)
         err_d = '0;
      else if (b_hs && (m_axil_bresp != 2'b00) && (err_q != '1))
         err_d = err_q + ERR_CNT_WIDTH'(1);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         outstanding_q <= '0;
         err_q         <= '0;
      end else begin
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
      end
   end

`ifdef AXIL_WR_TIMEOUT_EN
   localparam int WDW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WDW-1:0] wdog_q, wdog_d;
   logic           timeout_q, timeout_d;

   // Counter restarts after firing so a cleared flag needs a full fresh stall to set again
   always_comb begin
      wdog_d    = wdog_q;
      timeout_d = timeout_q;
      if ((outstanding_q == 4'd0) || b_hs) begin
         wdog_d = '0;
      end else if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
         wdog_d    = '0;
         timeout_d = 1'b1;
      end else begin
         wdog_d = wdog_q + WDW'(1);
      end
      if (err_clear) timeout_d = 1'b0;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wdog_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wdog_q    <= wdog_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign outstanding = outstanding_q;
   assign err_count   = err_q;
   assign busy        = aw_nempty | m_axil_wvalid | b_nempty | (outstanding_q != 4'd0)
                      | fub_awvalid | fub_wvalid | m_axil_bvalid;
endmodule

// File: tb/tb_axil4_master_wr_ctrl.sv
// Directed testbench for axil4_master_wr_ctrl with a queue-based reference model checked every cycle.
// Watchdog checks follow the AXIL_WR_TIMEOUT_EN macro of the build.

module tb_axil4_master_wr_ctrl;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int DEPTH   = 2;
   localparam int MAXO    = 2;
   localparam int TO      = 16;
   localparam int EW      = 4;
   localparam int ERR_MAX = 15;

   logic          aclk = 1'b0;
   logic          areset;
   logic [AW-1:0] fub_awaddr;
   logic [2:0]    fub_awprot;
   logic          fub_awvalid, fub_awready;
   logic [DW-1:0] fub_wdata;
   logic [3:0]    fub_wstrb;
   logic          fub_wvalid, fub_wready;
   logic [1:0]    fub_bresp;
   logic          fub_bvalid, fub_bready;
   logic [AW-1:0] m_axil_awaddr;
   logic [2:0]    m_axil_awprot;
   logic          m_axil_awvalid, m_axil_awready;
   logic [DW-1:0] m_axil_wdata;
   logic [3:0]    m_axil_wstrb;
   logic          m_axil_wvalid, m_axil_wready;
   logic [1:0]    m_axil_bresp;
   logic          m_axil_bvalid, m_axil_bready;
   logic [3:0]    outstanding;
   logic [EW-1:0] err_count;
   logic          timeout_err, err_clear, busy;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;

   axil4_master_wr_ctrl #(
      .AXIL_ADDR_WIDTH(AW), .AXIL_DATA_WIDTH(DW),
      .SKID_DEPTH_AW(DEPTH), .SKID_DEPTH_W(DEPTH), .SKID_DEPTH_B(DEPTH),
      .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO), .ERR_CNT_WIDTH(EW)
   ) dut (
      .aclk(aclk), .areset(areset),
      .fub_awaddr(fub_awaddr), .fub_awprot(fub_awprot),
      .fub_awvalid(fub_awvalid), .fub_awready(fub_awready),
      .fub_wdata(fub_wdata), .fub_wstrb(fub_wstrb),
      .fub_wvalid(fub_wvalid), .fub_wready(fub_wready),
      .fub_bresp(fub_bresp), .fub_bvalid(fub_bvalid), .fub_bready(fub_bready),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
      .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
      .outstanding(outstanding), .err_count(err_count), .timeout_err(timeout_err),
      .err_clear(err_clear), .busy(busy)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Reference model: contents of each buffer, outstanding count, error count, stall run
   logic [34:0] aw_mq[$];
   logic [35:0] w_mq[$];
   logic [1:0]  b_mq[$];
   int          m_out = 0;
   int          m_err = 0;
   int          m_wd  = 0;
   bit          m_to  = 1'b0;

   // Compare in mid-cycle, then advance the model to what the next edge must produce
   always @(negedge aclk) begin : model
      bit aw_in, w_in, aw_out, w_out, b_in, b_out;
      int out_old;
      if (cmp_en) begin
         chk("fub_awready", fub_awready, aw_mq.size() < DEPTH);
         chk("fub_wready", fub_wready, w_mq.size() < DEPTH);
         chk("m_awvalid", m_axil_awvalid, (aw_mq.size() > 0) && (m_out < MAXO));
         if (aw_mq.size() > 0) chk("m_aw_payload", {m_axil_awprot, m_axil_awaddr}, aw_mq[0]);
         chk("m_wvalid", m_axil_wvalid, w_mq.size() > 0);
         if (w_mq.size() > 0) chk("m_w_payload", {m_axil_wstrb, m_axil_wdata}, w_mq[0]);
         chk("m_bready", m_axil_bready, b_mq.size() < DEPTH);
         chk("fub_bvalid", fub_bvalid, b_mq.size() > 0);
         if (b_mq.size() > 0) chk("fub_bresp", fub_bresp, b_mq[0]);
         chk("outstanding", outstanding, m_out);
         chk("err_count", err_count, m_err);
         chk("timeout_err", timeout_err, m_to);
         chk("busy", busy, (aw_mq.size() + w_mq.size() + b_mq.size() > 0) || (m_out != 0)
                           || fub_awvalid || fub_wvalid || m_axil_bvalid);
      end
      if (areset) begin
         aw_mq.delete(); w_mq.delete(); b_mq.delete();
         m_out = 0; m_err = 0; m_wd = 0; m_to = 1'b0;
      end else begin
         out_old = m_out;
         aw_in  = fub_awvalid && (aw_mq.size() < DEPTH);
         w_in   = fub_wvalid && (w_mq.size() < DEPTH);
         aw_out = (aw_mq.size() > 0) && (m_out < MAXO) && m_axil_awready;
         w_out  = (w_mq.size() > 0) && m_axil_wready;
         b_in   = m_axil_bvalid && (b_mq.size() < DEPTH);
         b_out  = (b_mq.size() > 0) && fub_bready;
         if (aw_out) void'(aw_mq.pop_front());
         if (w_out)  void'(w_mq.pop_front());
         if (b_out)  void'(b_mq.pop_front());
         if (aw_in)  aw_mq.push_back({fub_awprot, fub_awaddr});
         if (w_in)   w_mq.push_back({fub_wstrb, fub_wdata});
         if (b_in)   b_mq.push_back(m_axil_bresp);
         if (aw_out && !b_in) m_out++;
         else if (b_in && !aw_out && m_out > 0) m_out--;
         if (err_clear) m_err = 0;
         else if (b_in && m_axil_bresp != 2'b00 && m_err < ERR_MAX) m_err++;
`ifdef AXIL_WR_TIMEOUT_EN
         if (out_old == 0 || b_in) m_wd = 0;
         else begin
            m_wd++;
            if (m_wd == TO) begin m_to = 1'b1; m_wd = 0; end
         end
         if (err_clear) m_to = 1'b0;
`endif
      end
   end

   // Observed master-side traffic for the directed checks
   int            aw_hs_cnt = 0;
   logic [DW-1:0] w_seen[$];
   always @(negedge aclk) begin
      if (m_axil_awvalid && m_axil_awready) aw_hs_cnt++;
      if (m_axil_wvalid && m_axil_wready) w_seen.push_back(m_axil_wdata);
   end

   task automatic send_aw(input logic [AW-1:0] a);
      int n = 0;
      fub_awvalid = 1'b1; fub_awaddr = a; fub_awprot = a[2:0];
      @(negedge aclk);
      while (!fub_awready && n < 50) begin n++; @(negedge aclk); end
      chk("aw_accept", fub_awready, 1);
      tick();
      fub_awvalid = 1'b0;
      $display("[TB] AW addr=0x%08h accepted", a);
   endtask

   task automatic send_b(input logic [1:0] r);
      int n = 0;
      m_axil_bvalid = 1'b1; m_axil_bresp = r;
      @(negedge aclk);
      while (!m_axil_bready && n < 50) begin n++; @(negedge aclk); end
      chk("b_accept", m_axil_bready, 1);
      tick();
      m_axil_bvalid = 1'b0;
      $display("[TB] B resp=%0d delivered", r);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish in time");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "global timeout");
   end

   initial begin
      logic [DW-1:0] wexp[3];
      int            base;
      areset = 1'b1; err_clear = 1'b0;
      fub_awaddr = '0; fub_awprot = '0; fub_awvalid = 1'b0;
      fub_wdata = '0; fub_wstrb = '0; fub_wvalid = 1'b0; fub_bready = 1'b0;
      m_axil_awready = 1'b0; m_axil_wready = 1'b0;
      m_axil_bresp = '0; m_axil_bvalid = 1'b0;
      repeat (2) tick();
      areset = 1'b0; cmp_en = 1'b1;
      @(negedge aclk);
      chk("rst_awvalid", m_axil_awvalid, 0);
      chk("rst_wvalid", m_axil_wvalid, 0);
      chk("rst_bvalid", fub_bvalid, 0);
      chk("rst_awready", fub_awready, 1);
      chk("rst_wready", fub_wready, 1);
      chk("rst_bready", m_axil_bready, 1);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_busy", busy, 0);

      // Single write
      tick();
      m_axil_awready = 1'b1; m_axil_wready = 1'b1; fub_bready = 1'b1;
      fub_awvalid = 1'b1; fub_awaddr = 32'h1000; fub_awprot = 3'd0;
      fub_wvalid = 1'b1; fub_wdata = 32'hA5A5_A5A5; fub_wstrb = 4'hF;
      tick();
      fub_awvalid = 1'b0; fub_wvalid = 1'b0;
      @(negedge aclk);
      chk("single_awvalid", m_axil_awvalid, 1);
      chk("single_awaddr", m_axil_awaddr, 32'h1000);
      chk("single_wvalid", m_axil_wvalid, 1);
      chk("single_wdata", m_axil_wdata, 32'hA5A5_A5A5);
      chk("single_wstrb", m_axil_wstrb, 4'hF);
      tick();
      @(negedge aclk);
      chk("single_outstanding1", outstanding, 1);
      tick();
      m_axil_bvalid = 1'b1; m_axil_bresp = 2'b00;
      tick();
      m_axil_bvalid = 1'b0;
      @(negedge aclk);
      chk("single_fub_bvalid", fub_bvalid, 1);
      chk("single_outstanding0", outstanding, 0);
      chk("single_err", err_count, 0);
      $display("[TB] single write done");

      // Outstanding cap
      tick();
      base = aw_hs_cnt;
      send_aw(32'h2000); send_aw(32'h2004); send_aw(32'h2008); send_aw(32'h200C);
      repeat (4) tick();
      @(negedge aclk);
      chk("cap_hs_count", aw_hs_cnt - base, 2);
      chk("cap_outstanding", outstanding, 2);
      chk("cap_awvalid_low", m_axil_awvalid, 0);
      chk("cap_fifo_full", fub_awready, 0);
      tick();
      send_b(2'b00);
      @(negedge aclk);
      chk("cap_release_out", outstanding, 1);
      chk("cap_release_awvalid", m_axil_awvalid, 1);
      chk("cap_release_addr", m_axil_awaddr, 32'h2008);
      tick();
      send_b(2'b00); send_b(2'b00); send_b(2'b00);
      @(negedge aclk);
      chk("cap_drain_out", outstanding, 0);
      chk("cap_total_hs", aw_hs_cnt - base, 4);

      // W backpressure
      tick();
      w_seen.delete();
      wexp[0] = 32'h1111_0001; wexp[1] = 32'h2222_0002; wexp[2] = 32'h3333_0003;
      m_axil_wready = 1'b0;
      fub_wvalid = 1'b1; fub_wstrb = 4'hF; fub_wdata = wexp[0];
      tick();
      fub_wdata = wexp[1];
      tick();
      fub_wdata = wexp[2];
      @(negedge aclk);
      chk("bp_wready_full", fub_wready, 0);
      chk("bp_head", m_axil_wdata, wexp[0]);
      repeat (3) tick();
      @(negedge aclk);
      chk("bp_wready_hold", fub_wready, 0);
      tick();
      m_axil_wready = 1'b1;
      begin
         int n = 0;
         @(negedge aclk);
         while (!fub_wready && n < 50) begin n++; @(negedge aclk); end
         chk("bp_third_accept", fub_wready, 1);
      end
      tick();
      fub_wvalid = 1'b0;
      repeat (4) tick();
      @(negedge aclk);
      chk("bp_beat_count", w_seen.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < w_seen.size()) chk($sformatf("bp_beat%0d", i), w_seen[i], wexp[i]);
      $display("[TB] W backpressure done, %0d beats out", w_seen.size());

      // Error accounting
      tick();
      send_b(2'b10); send_b(2'b00); send_b(2'b11);
      @(negedge aclk);
      chk("err_count_2", err_count, 2);
      chk("err_out_hold0", outstanding, 0);
      tick();
      m_axil_bvalid = 1'b1; m_axil_bresp = 2'b10; err_clear = 1'b1;
      tick();
      m_axil_bvalid = 1'b0; err_clear = 1'b0;
      @(negedge aclk);
      chk("err_clear_prio", err_count, 0);
      tick();
      for (int i = 0; i < 17; i++) send_b(2'b11);
      @(negedge aclk);
      chk("err_saturate", err_count, 4'hF);
      tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      @(negedge aclk);
      chk("err_cleared", err_count, 0);

      // Watchdog
      tick();
      send_aw(32'h3000);
      tick();
`ifdef AXIL_WR_TIMEOUT_EN
      for (int k = 1; k <= TO; k++) begin
         tick();
         @(negedge aclk);
         chk($sformatf("wd_edge%0d", k), timeout_err, (k == TO) ? 1 : 0);
      end
      tick();
      send_b(2'b00);
      @(negedge aclk);
      chk("wd_sticky", timeout_err, 1);
      chk("wd_out0", outstanding, 0);
      repeat (3) tick();
      @(negedge aclk);
      chk("wd_sticky_later", timeout_err, 1);
      tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      @(negedge aclk);
      chk("wd_cleared", timeout_err, 0);
`else
      repeat (20) tick();
      @(negedge aclk);
      chk("wd_absent", timeout_err, 0);
      chk("wd_out1", outstanding, 1);
      tick();
      send_b(2'b00);
`endif
      $display("[TB] watchdog phase done");

      // Reset mid-operation
      tick();
      send_aw(32'h4000);
      tick();
      m_axil_awready = 1'b0; m_axil_wready = 1'b0;
      send_aw(32'h4004); send_aw(32'h4008);
      fub_wvalid = 1'b1; fub_wdata = 32'hDEAD_BEEF;
      tick();
      fub_wvalid = 1'b0;
      @(negedge aclk);
      chk("mid_out1", outstanding, 1);
      chk("mid_aw_full", fub_awready, 0);
      tick();
      areset = 1'b1;
      tick();
      areset = 1'b0;
      @(negedge aclk);
      chk("mrst_awvalid", m_axil_awvalid, 0);
      chk("mrst_wvalid", m_axil_wvalid, 0);
      chk("mrst_bvalid", fub_bvalid, 0);
      chk("mrst_out", outstanding, 0);
      chk("mrst_awready", fub_awready, 1);
      chk("mrst_wready", fub_wready, 1);
      chk("mrst_bready", m_axil_bready, 1);
      repeat (2) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
